// File: rtl/inject_arb_pkg.sv
// Shared types, constants and the round-robin pick function for inject_arbiter_vc.
package inject_arb_pkg;

  localparam int unsigned STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Upper bound on requesters the pick function can scan
  localparam int unsigned MAX_REQ  = 32;
  localparam int unsigned MAX_IDW  = 5;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n (ptr < n <= MAX_REQ)
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int unsigned        ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = ptr + i;
        if (j >= n) j = j - n;
        if (!res.found && req[j]) begin
          res.found = 1'b1;
          res.idx   = MAX_IDW'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/inject_arbiter_vc_rr_arbiter.sv
// Combinational round-robin picker: lowest-distance valid requester from ptr_i.
module rr_arbiter
  import inject_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               found_c_o,
  output logic [IDW-1:0]     idx_c_o
);

  rr_pick_t pick_c;

  // Scan requests starting at the pointer
  always_comb begin
    pick_c    = rr_pick(MAX_REQ'(req_i), 32'(ptr_i), NUM_REQ);
    found_c_o = pick_c.found;
    idx_c_o   = IDW'(pick_c.idx);
  end

endmodule

// File: rtl/inject_arbiter_vc.sv
// Round-robin arbiter sharing one packetizer injection port among NUM_REQ requesters,
// through a one-entry output register (1 word/clk, 1 cycle latency).
// Optional grant statistics: define INJECT_ARBITER_STATS_EN.
module inject_arbiter_vc
  import inject_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ       = 4,
  parameter  int unsigned ADDRESS_WIDTH = 4,
  parameter  int unsigned WIDTH_IN      = 12,
  localparam int unsigned GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*WIDTH_IN-1:0]       req_data_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_dst_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [WIDTH_IN-1:0]               data_out,
  output logic [ADDRESS_WIDTH-1:0]          dst_out,
  output logic                              valid_out,
  input  logic                              ready_in,
`ifdef INJECT_ARBITER_STATS_EN
  input  logic [GW-1:0]                     stat_sel_in,
  output logic [STAT_W-1:0]                 stat_count_out,
`endif
  output logic [GW-1:0]                     grant_id_out
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH_IN-1:0]      data_q,  data_d;
  logic [ADDRESS_WIDTH-1:0] dst_q,   dst_d;
  logic [GW-1:0]            gid_q,   gid_d;
  logic [GW-1:0]            ptr_q,   ptr_d;

  logic                     found_c;
  logic [GW-1:0]            win_c;
  logic                     load_en_c;
  logic                     load_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (GW)
  ) u_rr (
    .req_i     (req_valid_in),
    .ptr_i     (ptr_q),
    .found_c_o (found_c),
    .idx_c_o   (win_c)
  );

  // Next-state, register load and ready generation
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    dst_d         = dst_q;
    gid_d         = gid_q;
    ptr_d         = ptr_q;
    req_ready_out = '0;
    load_en_c     = (state_q == ST_EMPTY) | ready_in;
    load_c        = load_en_c & found_c;

    if (load_en_c) begin
      if (found_c) begin
        state_d = ST_FULL;
        gid_d   = win_c;
        ptr_d   = (32'(win_c) == NUM_REQ - 1) ? '0 : win_c + GW'(1);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (GW'(i) == win_c) begin
            data_d           = req_data_in[i*WIDTH_IN +: WIDTH_IN];
            dst_d            = req_dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            req_ready_out[i] = rst_n;
          end
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      dst_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_out    = (state_q == ST_FULL);
  assign data_out     = data_q;
  assign dst_out      = dst_q;
  assign grant_id_out = gid_q;

`ifdef INJECT_ARBITER_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] cnt_d [NUM_REQ];

  // Saturating per-requester grant counters
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (load_c && (GW'(i) == win_c) && (cnt_q[i] != STAT_MAX)) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Counter readback mux
  always_comb begin
    stat_count_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == stat_sel_in) stat_count_out = cnt_q[i];
    end
  end
`else
  logic unused_load_c;
  assign unused_load_c = load_c;
`endif

endmodule

// File: tb/tb_inject_arbiter_vc.sv
// Directed self-checking bench for inject_arbiter_vc (NUM_REQ=4, ADDRESS_WIDTH=4, WIDTH_IN=12).
// Stats checks are compiled in when INJECT_ARBITER_STATS_EN is defined.
module tb_inject_arbiter_vc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] req_data_in = '0;
  logic [15:0] req_dst_in = '0;
  logic [3:0]  req_valid_in = '0;
  logic [3:0]  req_ready_out;
  logic [11:0] data_out;
  logic [3:0]  dst_out;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [1:0]  grant_id_out;
`ifdef INJECT_ARBITER_STATS_EN
  logic [1:0]  stat_sel_in = '0;
  logic [15:0] stat_count_out;
  int unsigned model_cnt [4];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] d;
    logic [3:0]  a;
  } word_t;
  word_t sb[$];

  always #5 clk = ~clk;

  inject_arbiter_vc #(
    .NUM_REQ       (4),
    .ADDRESS_WIDTH (4),
    .WIDTH_IN      (12)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_data_in    (req_data_in),
    .req_dst_in     (req_dst_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .data_out       (data_out),
    .dst_out        (dst_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
`ifdef INJECT_ARBITER_STATS_EN
    .stat_sel_in    (stat_sel_in),
    .stat_count_out (stat_count_out),
`endif
    .grant_id_out   (grant_id_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [11:0] d, input logic [3:0] a);
    req_data_in[i*12 +: 12] = d;
    req_dst_in[i*4 +: 4]    = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes seen mid-cycle take effect on the following rising edge
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      sb.delete();
`ifdef INJECT_ARBITER_STATS_EN
      for (int i = 0; i < 4; i++) model_cnt[i] = 0;
`endif
    end else begin
      chk("ready_onehot", 32'($countones(req_ready_out) <= 1), 1);
      if (valid_out && ready_in) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", sb.size(), 1);
        end else begin
          w = sb.pop_front();
          chk("sb_data", data_out, w.d);
          chk("sb_dst", dst_out, w.a);
          chk("sb_id", grant_id_out, w.id);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_ready_out[i] && req_valid_in[i]) begin
          w.id = 2'(i);
          w.d  = req_data_in[i*12 +: 12];
          w.a  = req_dst_in[i*4 +: 4];
          sb.push_back(w);
`ifdef INJECT_ARBITER_STATS_EN
          if (model_cnt[i] < 65535) model_cnt[i]++;
`endif
        end
      end
    end
  end

  initial begin
    set_word(0, 12'h001, 4'h1);
    set_word(1, 12'h112, 4'h2);
    set_word(2, 12'h223, 4'h3);
    set_word(3, 12'h334, 4'h4);
    req_valid_in = 4'hF;
    ready_in     = 1'b1;

    // Reset held with every requester valid
    repeat (2) step();
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", req_ready_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_dst", dst_out, 0);
    chk("rst_gid", grant_id_out, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", req_ready_out, 4'b0001);

    // All valid, full throughput round robin
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_gid", grant_id_out, 32'(k % 4));
      chk("rr_valid", valid_out, 1);
      if (k == 0) begin
        chk("rr_data0", data_out, 12'h001);
        chk("rr_dst0", dst_out, 4'h1);
      end
    end

    // Backpressure with word ABC/5 held in the register
    set_word(2, 12'hABC, 4'h5);
    step();
    chk("bp_load_data", data_out, 12'hABC);
    chk("bp_load_dst", dst_out, 4'h5);
    chk("bp_load_gid", grant_id_out, 2);
    ready_in = 1'b0;
    #1;
    chk("bp_ready0", req_ready_out, 0);
    repeat (5) begin
      step();
      chk("bp_data", data_out, 12'hABC);
      chk("bp_dst", dst_out, 4'h5);
      chk("bp_gid", grant_id_out, 2);
      chk("bp_valid", valid_out, 1);
      chk("bp_ready", req_ready_out, 0);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_release_ready", req_ready_out, 4'b1000);
    step();
    chk("bp_next_gid", grant_id_out, 3);
    chk("bp_next_data", data_out, 12'h334);
    chk("bp_next_dst", dst_out, 4'h4);

    // Sparse requests with wrap: move ptr to 2 via req1, then req3/req1 alternate
    req_valid_in = 4'b0010;
    step();
    chk("sp_gid_setup", grant_id_out, 1);
    req_valid_in = 4'b1010;
    #1;
    chk("sp_ready", req_ready_out, 4'b1000);
    step();
    chk("sp_gid_a", grant_id_out, 3);
    step();
    chk("sp_gid_b", grant_id_out, 1);
    step();
    chk("sp_gid_c", grant_id_out, 3);

    // No requester: register empties, payload holds
    req_valid_in = 4'b0000;
    #1;
    chk("idle_ready", req_ready_out, 0);
    step();
    chk("idle_valid", valid_out, 0);
    chk("idle_data", data_out, 12'h334);
    chk("idle_gid", grant_id_out, 3);

    // Reset in the middle of a stream
    req_valid_in = 4'hF;
    #1;
    chk("mr_ready", req_ready_out, 4'b0001);
    step();
    chk("mr_gid0", grant_id_out, 0);
    step();
    chk("mr_gid1", grant_id_out, 1);
    chk("mr_data1", data_out, 12'h112);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", valid_out, 0);
    chk("mr_rst_data", data_out, 0);
    chk("mr_rst_gid", grant_id_out, 0);
    chk("mr_rst_ready", req_ready_out, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_ready", req_ready_out, 4'b0001);
    step();
    chk("mr_restart_gid", grant_id_out, 0);
    chk("mr_restart_data", data_out, 12'h001);

`ifdef INJECT_ARBITER_STATS_EN
    // Saturate requester 2's counter
    req_valid_in = 4'b0100;
    repeat (66000) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      stat_sel_in = 2'(i);
      #1;
      if (i == 2) chk("stat_sat", stat_count_out, 16'hFFFF);
      else        chk("stat_other", stat_count_out, model_cnt[i]);
    end
`endif

    // Drain and confirm every accepted word was delivered
    req_valid_in = 4'b0000;
    step();
    chk("drain_valid", valid_out, 0);
    step();
    chk("sb_leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
